mult_dot_acc: RTL and testbench

- Streaming signed dot-product accumulator directly downstream of the registered 16x16 approximate radix-4 Booth multiplier wrapper.
- Consumes one 32-bit signed product per cycle and sums the products of one vector with saturation.
- Presents each completed sum on a valid/ready output port, while accumulation of the next vector continues.
- The integration level delays the operand-valid by 2 cycles so that p_valid aligns with the wrapper's registered product.

---
 rtl/mult_pkg.sv | 53 +++++
 rtl/mult_dot_acc_sat_add.sv | 21 ++
 rtl/mult_dot_acc.sv | 159 +++++++++++++++
 tb/tb_mult_dot_acc.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapath blocks.
//   PROD_W   : width of one signed product from the Booth multiplier wrapper.
//   state_e  : dot-product accumulator states.
//   sat_max / sat_min : two's complement bounds of a w-bit signed value.
//   sat_add  : saturating add of two sign-extended operands at width w.
//              Returns the clamped sum and raises ovf when clamping occurred.
package mult_pkg;

  localparam int PROD_W = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Largest positive value representable in w signed bits.
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Most negative value representable in w signed bits.
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  // Operands arrive sign-extended to 64 bits. The sum is taken one bit wider
  // than the operands so that no intermediate result can wrap, then compared
  // against the w-bit bounds.
  function automatic logic [63:0] sat_add(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input int                 w,
                                          output logic              ovf);
    logic signed [64:0] wide;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    logic        [63:0] res;
    wide = $signed({a[63], a}) + $signed({b[63], b});
    hi   = sat_max(w);
    lo   = sat_min(w);
    if (wide > hi) begin
      res = sat_max(w);
      ovf = 1'b1;
    end else if (wide < lo) begin
      res = sat_min(w);
      ovf = 1'b1;
    end else begin
      res = wide[63:0];
      ovf = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/mult_dot_acc_sat_add.sv
// Combinational ACC_W-bit signed saturating adder.
//   a_i, b_i : signed operands, ACC_W bits.
//   sum_o    : a_i + b_i clamped to the ACC_W signed range.
//   ovf_o    : 1 when the true sum fell outside the range and was clamped.
module mult_dot_acc_sat_add
  import mult_pkg::*;
#(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

  // Sign-extend both operands and narrow the clamped result back to ACC_W.
  always_comb begin
    sum_o = ACC_W'(sat_add(64'(signed'(a_i)), 64'(signed'(b_i)), ACC_W, ovf_o));
  end

endmodule

// File: rtl/mult_dot_acc.sv
// Streaming signed dot-product accumulator.
// Sums one 32-bit signed product per accepted cycle with saturation and
// presents each completed vector sum on a valid/ready result port while the
// next vector keeps accumulating.
//   clk, rst_n  : clock, asynchronous active-low reset.
//   p_in        : signed product; p_valid qualifies p_in and p_last.
//   p_last      : product closes the current vector.
//   p_ready     : product is accepted this cycle (!acc_valid || acc_ready).
//   acc_out     : completed signed sum; acc_cnt its product count.
//   acc_sat     : saturation occurred within the vector.
//   acc_lenerr  : vector was closed at MAX_LEN without p_last.
//   acc_valid / acc_ready : result handshake.
module mult_dot_acc
  import mult_pkg::*;
#(
  parameter int ACC_W   = 40,
  parameter int MAX_LEN = 256,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] p_in,
  input  logic              p_valid,
  input  logic              p_last,
  output logic              p_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic [CNT_W-1:0]  acc_cnt,
  output logic              acc_sat,
  output logic              acc_lenerr,
  output logic              acc_valid,
  input  logic              acc_ready
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic [ACC_W-1:0]   out_q, out_d;
  logic [CNT_W-1:0]   ocnt_q, ocnt_d;
  logic               osat_q, osat_d;
  logic               olen_q, olen_d;
  logic               ovalid_q, ovalid_d;

  logic               accept_s;
  logic               close_s;
  logic               full_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic [ACC_W-1:0]   prod_ext_s;
  logic [ACC_W-1:0]   sum_s;
  logic               ovf_s;

  // Upstream is only held off while a finished result waits for downstream.
  assign p_ready    = !ovalid_q || acc_ready;
  assign accept_s   = p_valid && p_ready;
  assign cnt_inc_s  = cnt_q + CNT_W'(1);
  assign full_s     = (cnt_inc_s == CNT_W'(MAX_LEN));
  assign close_s    = accept_s && (p_last || full_s);
  assign prod_ext_s = ACC_W'(signed'(p_in));

  mult_dot_acc_sat_add #(
    .ACC_W (ACC_W)
  ) u_sat_add (
    .a_i   (acc_q),
    .b_i   (prod_ext_s),
    .sum_o (sum_s),
    .ovf_o (ovf_s)
  );

  // State, accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      out_q    <= '0;
      ocnt_q   <= '0;
      osat_q   <= 1'b0;
      olen_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      out_q    <= out_d;
      ocnt_q   <= ocnt_d;
      osat_q   <= osat_d;
      olen_q   <= olen_d;
      ovalid_q <= ovalid_d;
    end
  end

  // Next-state FSM, accumulation datapath and result register loading.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    out_d    = out_q;
    ocnt_d   = ocnt_q;
    osat_d   = osat_q;
    olen_d   = olen_q;
    ovalid_d = ovalid_q;

    // A single-element vector closes straight from IDLE and never leaves it.
    case (state_q)
      IDLE: begin
        if (accept_s && !close_s) begin
          state_d = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (close_s) begin
          state_d = IDLE;
        end else begin
          state_d = ACCUM;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (close_s) begin
      acc_d = '0;
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (accept_s) begin
      acc_d = sum_s;
      cnt_d = cnt_inc_s;
      sat_d = sat_q || ovf_s;
    end else begin
      acc_d = acc_q;
    end

    // A close in the same cycle as a take overwrites the result with no bubble.
    if (close_s) begin
      out_d    = sum_s;
      ocnt_d   = cnt_inc_s;
      osat_d   = sat_q || ovf_s;
      olen_d   = !p_last;
      ovalid_d = 1'b1;
    end else if (ovalid_q && acc_ready) begin
      ovalid_d = 1'b0;
    end else begin
      ovalid_d = ovalid_q;
    end
  end

  assign acc_out    = out_q;
  assign acc_cnt    = ocnt_q;
  assign acc_sat    = osat_q;
  assign acc_lenerr = olen_q;
  assign acc_valid  = ovalid_q;

endmodule

// File: tb/tb_mult_dot_acc.sv
// Directed and randomised bench for mult_dot_acc, built with ACC_W=33 and
// MAX_LEN=4 so that saturation and forced closes are reachable quickly.
module tb_mult_dot_acc;

  localparam int ACC_W   = 33;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = 16;
  localparam longint MAXV = 64'sd4294967295;
  localparam longint MINV = -64'sd4294967296;
  localparam logic [63:0] MASK = 64'h0000_0001_FFFF_FFFF;

  logic              clk;
  logic              rst_n;
  logic [31:0]       p_in;
  logic              p_valid;
  logic              p_last;
  logic              p_ready;
  logic [ACC_W-1:0]  acc_out;
  logic [CNT_W-1:0]  acc_cnt;
  logic              acc_sat;
  logic              acc_lenerr;
  logic              acc_valid;
  logic              acc_ready;

  int checks = 0;
  int errors = 0;

  mult_dot_acc #(
    .ACC_W   (ACC_W),
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p_in       (p_in),
    .p_valid    (p_valid),
    .p_last     (p_last),
    .p_ready    (p_ready),
    .acc_out    (acc_out),
    .acc_cnt    (acc_cnt),
    .acc_sat    (acc_sat),
    .acc_lenerr (acc_lenerr),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input longint eo, input int ec,
                         input logic es, input logic el);
    chk({tag, ".valid"},  64'(acc_valid),  64'd1);
    chk({tag, ".out"},    64'(acc_out),    64'(eo) & MASK);
    chk({tag, ".cnt"},    64'(acc_cnt),    64'(ec));
    chk({tag, ".sat"},    64'(acc_sat),    64'(es));
    chk({tag, ".lenerr"}, 64'(acc_lenerr), 64'(el));
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic r);
    p_valid   = v;
    p_in      = d;
    p_last    = l;
    acc_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic l, input logic r);
    drive(v, d, l, r);
    tick();
  endtask

  // Reference state for the random phase.
  logic   m_valid;
  longint m_acc;
  longint m_out;
  int     m_cnt;
  int     m_ocnt;
  logic   m_sat;
  logic   m_osat;
  logic   m_len;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    #12;
    chk("rst.valid",  64'(acc_valid),  64'd0);
    chk("rst.out",    64'(acc_out),    64'd0);
    chk("rst.cnt",    64'(acc_cnt),    64'd0);
    chk("rst.sat",    64'(acc_sat),    64'd0);
    chk("rst.lenerr", 64'(acc_lenerr), 64'd0);
    rst_n = 1'b1;
    tick();

    // Simple vector 100 - 40 + 7.
    drive(1'b1, 32'd100, 1'b0, 1'b1);
    #1;
    chk("simple.p_ready", 64'(p_ready), 64'd1);
    tick();
    step(1'b1, -32'sd40, 1'b0, 1'b1);
    chk("simple.mid_valid", 64'(acc_valid), 64'd0);
    step(1'b1, 32'd7, 1'b1, 1'b1);
    chk_res("simple", 64'sd67, 3, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("simple.release", 64'(acc_valid), 64'd0);

    // Back-to-back with a downstream stall.
    step(1'b1, 32'd5, 1'b0, 1'b0);
    step(1'b1, 32'd5, 1'b1, 1'b0);
    chk_res("b2b.first", 64'sd10, 2, 1'b0, 1'b0);
    drive(1'b1, -32'sd3, 1'b1, 1'b0);
    #1;
    chk("b2b.stall_p_ready", 64'(p_ready), 64'd0);
    tick();
    chk_res("b2b.hold1", 64'sd10, 2, 1'b0, 1'b0);
    tick();
    chk_res("b2b.hold2", 64'sd10, 2, 1'b0, 1'b0);
    drive(1'b1, -32'sd3, 1'b1, 1'b1);
    #1;
    chk("b2b.take_p_ready", 64'(p_ready), 64'd1);
    tick();
    chk_res("b2b.second", -64'sd3, 1, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("b2b.release", 64'(acc_valid), 64'd0);

    // Saturation at 33 bits.
    step(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    step(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    chk_res("sat.fits", 64'sd4294967294, 2, 1'b0, 1'b0);
    step(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    chk("sat.taken", 64'(acc_valid), 64'd0);
    step(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    step(1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
    chk_res("sat.pos", MAXV, 3, 1'b1, 1'b0);
    step(1'b1, 32'h8000_0000, 1'b0, 1'b1);
    step(1'b1, 32'h8000_0000, 1'b0, 1'b1);
    step(1'b1, 32'h8000_0000, 1'b1, 1'b1);
    chk_res("sat.neg", MINV, 3, 1'b1, 1'b0);
    // Continue from the clamped maximum; p_last lands exactly on MAX_LEN.
    step(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    step(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    step(1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    step(1'b1, 32'h8000_0000, 1'b1, 1'b1);
    chk_res("sat.clamp_cont", 64'sd2147483647, 4, 1'b1, 1'b0);

    // Forced close at MAX_LEN, then a short vector ended by p_last.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'd1, 1'b0, 1'b1);
    end
    chk_res("force.first", 64'sd4, 4, 1'b0, 1'b1);
    step(1'b1, 32'd1, 1'b0, 1'b1);
    chk("force.gap", 64'(acc_valid), 64'd0);
    step(1'b1, 32'd1, 1'b1, 1'b1);
    chk_res("force.second", 64'sd2, 2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a vector.
    step(1'b1, 32'd20, 1'b0, 1'b1);
    step(1'b1, 32'd30, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.valid",  64'(acc_valid),  64'd0);
    chk("mrst.out",    64'(acc_out),    64'd0);
    chk("mrst.cnt",    64'(acc_cnt),    64'd0);
    chk("mrst.sat",    64'(acc_sat),    64'd0);
    chk("mrst.lenerr", 64'(acc_lenerr), 64'd0);
    drive(1'b0, 32'd0, 1'b0, 1'b1);
    #1;
    rst_n = 1'b1;
    tick();
    step(1'b1, 32'd9, 1'b1, 1'b1);
    chk_res("mrst.after", 64'sd9, 1, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    chk("mrst.release", 64'(acc_valid), 64'd0);

    // Random streaming against a cycle-level reference.
    m_valid = 1'b0;
    m_acc   = 0;
    m_out   = 0;
    m_cnt   = 0;
    m_ocnt  = 0;
    m_sat   = 1'b0;
    m_osat  = 1'b0;
    m_len   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic        v;
      logic        l;
      logic        r;
      logic        exp_rdy;
      logic        ov;
      logic [31:0] d;
      longint      s;
      int          nc;
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0:       d = 32'h7FFF_FFFF;
        1:       d = 32'h8000_0000;
        2:       d = 32'($urandom_range(0, 200)) - 32'd100;
        default: d = $urandom();
      endcase
      drive(v, d, l, r);
      #1;
      exp_rdy = !m_valid || r;
      chk("rnd.p_ready", 64'(p_ready), 64'(exp_rdy));
      if (m_valid && r) m_valid = 1'b0;
      if (v && exp_rdy) begin
        s  = m_acc + longint'($signed(d));
        ov = 1'b0;
        if (s > MAXV) begin
          s  = MAXV;
          ov = 1'b1;
        end else if (s < MINV) begin
          s  = MINV;
          ov = 1'b1;
        end
        nc = m_cnt + 1;
        if (l || nc == MAX_LEN) begin
          m_out   = s;
          m_ocnt  = nc;
          m_osat  = m_sat | ov;
          m_len   = !l;
          m_valid = 1'b1;
          m_acc   = 0;
          m_cnt   = 0;
          m_sat   = 1'b0;
        end else begin
          m_acc = s;
          m_cnt = nc;
          m_sat = m_sat | ov;
        end
      end
      tick();
      if (m_valid) begin
        chk_res("rnd", m_out, m_ocnt, m_osat, m_len);
      end else begin
        chk("rnd.valid", 64'(acc_valid), 64'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
